// File: rtl/exe_muldiv_unit_if.sv
// EXE-stage handshake between the pipeline and the RV32M multiply/divide unit.
interface exe_muldiv_unit_if;
  logic [31:0] inst_E;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        hold;
  logic        md_stall;
  logic        md_valid;
  logic [31:0] md_result;

  modport master (
    output inst_E, rs1_data, rs2_data, flush, hold,
    input  md_stall, md_valid, md_result
  );

  modport slave (
    input  inst_E, rs1_data, rs2_data, flush, hold,
    output md_stall, md_valid, md_result
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M unit: single-cycle-register multiply, restoring radix-2^k divide.
// Stalls the front of the pipe while busy and presents the result for one advancing cycle.
module exe_muldiv_unit #(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  exe_muldiv_unit_if.slave md
);
  localparam int N = XLEN / DIV_BITS_PER_CYCLE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opa_q, opb_q, rem_q, res_q;
  logic [5:0]      cnt_q;
  logic            neg_q_q, neg_r_q;

  // decode of the instruction sitting in EXE
  logic            is_md;
  logic [2:0]      f3;
  logic [XLEN-1:0] a, b, a_abs, b_abs;
  logic            div_sgn, div_ovf, div_zero;

  assign is_md    = (md.inst_E[6:0] == 7'b0110011) && (md.inst_E[31:25] == 7'b0000001);
  assign f3       = md.inst_E[14:12];
  assign a        = md.rs1_data;
  assign b        = md.rs2_data;
  assign div_sgn  = !f3[0];
  assign div_zero = (b == '0);
  assign div_ovf  = div_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
  assign a_abs    = (div_sgn && a[XLEN-1]) ? -a : a;
  assign b_abs    = (div_sgn && b[XLEN-1]) ? -b : b;

  // multiply: signedness is applied by extending to the full product width
  logic              sa, sb;
  logic [2*XLEN-1:0] xa, xb, prod;

  assign sa   = (op_q == 3'b001) || (op_q == 3'b010);
  assign sb   = (op_q == 3'b001);
  assign xa   = {{XLEN{sa & opa_q[XLEN-1]}}, opa_q};
  assign xb   = {{XLEN{sb & opb_q[XLEN-1]}}, opb_q};
  assign prod = xa * xb;

  // divide: opa_q shifts the dividend out and the quotient in; opb_q is |divisor|
  logic [XLEN:0]   t;
  logic [XLEN-1:0] q_nx, r_nx, q_fix, r_fix;

  always_comb begin
    q_nx = opa_q;
    r_nx = rem_q;
    t    = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      t    = {r_nx, q_nx[XLEN-1]};
      q_nx = {q_nx[XLEN-2:0], 1'b0};
      if (t >= {1'b0, opb_q}) begin
        t       = t - {1'b0, opb_q};
        q_nx[0] = 1'b1;
      end
      r_nx = t[XLEN-1:0];
    end
  end

  assign q_fix = neg_q_q ? -q_nx : q_nx;
  assign r_fix = neg_r_q ? -r_nx : r_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (md.flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (is_md) begin
          op_q <= f3;
          if (!f3[2]) begin
            opa_q   <= a;
            opb_q   <= b;
            state_q <= S_MUL;
          end else if (div_zero) begin
            res_q   <= f3[1] ? a : {XLEN{1'b1}};
            state_q <= S_DONE;
          end else if (div_ovf) begin
            res_q   <= f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_q <= S_DONE;
          end else begin
            opa_q   <= a_abs;
            opb_q   <= b_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= div_sgn && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_q <= div_sgn && a[XLEN-1];
            state_q <= S_DIV;
          end
        end
        S_MUL: begin
          res_q   <= (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_q <= S_DONE;
        end
        S_DIV: begin
          opa_q <= q_nx;
          rem_q <= r_nx;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(N-1)) begin
            res_q   <= op_q[1] ? r_fix : q_fix;
            state_q <= S_DONE;
          end
        end
        default: if (!md.hold) state_q <= S_IDLE;
      endcase
    end
  end

  assign md.md_stall  = is_md && (state_q != S_DONE) && !md.flush;
  assign md.md_valid  = (state_q == S_DONE) && !md.flush;
  assign md.md_result = res_q;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: latency, results, special cases, flush, hold, reset.
module tb_exe_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  exe_muldiv_unit_if mif ();

  exe_muldiv_unit #(.XLEN(32), .DIV_BITS_PER_CYCLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 10'd0, f3, 5'd1, 7'b0110011};
  endfunction

  // issue one M op right after a rising edge and wait for its result
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic [31:0] exp_res);
    int st;
    bit got;
    @(posedge clk); #1;
    mif.inst_E = mk(f3); mif.rs1_data = a; mif.rs2_data = b;
    st = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (mif.md_valid) got = 1'b1;
      else if (mif.md_stall) st++;
    end
    chk({tag, " valid"}, 32'(got), 32'd1);
    chk({tag, " stalls"}, st, exp_stall);
    chk({tag, " result"}, mif.md_result, exp_res);
    if (got) chk({tag, " stall@done"}, 32'(mif.md_stall), 32'd0);
  endtask

  task automatic no_valid(input string tag, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (mif.md_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    mif.inst_E = '0; mif.rs1_data = '0; mif.rs2_data = '0;
    mif.flush = 1'b0; mif.hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(mif.md_valid), 32'd0);
    chk("rst result", mif.md_result, 32'd0);
    chk("rst stall", 32'(mif.md_stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // multiply family, back to back
    run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 2, 32'hFFFFFFEB);
    run_op("MULH",   3'b001, 32'h80000000, 32'hFFFFFFFF, 2, 32'h00000000);
    run_op("MULHSU", 3'b010, 32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000);
    run_op("MULHU",  3'b011, 32'h80000000, 32'hFFFFFFFF, 2, 32'h7FFFFFFF);
    // iterative divide
    run_op("DIV",    3'b100, 32'hFFFFFFEC, 32'd3, 33, 32'hFFFFFFFA);
    run_op("REM",    3'b110, 32'hFFFFFFEC, 32'd3, 33, 32'hFFFFFFFE);
    run_op("DIVU",   3'b101, 32'd100, 32'd7, 33, 32'd14);
    run_op("REMU",   3'b111, 32'd100, 32'd7, 33, 32'd2);
    run_op("DIV7n2", 3'b100, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD);
    run_op("REM7n2", 3'b110, 32'd7, 32'hFFFFFFFE, 33, 32'd1);
    // special cases resolve in one stall cycle
    run_op("DIVU/0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
    run_op("REM/0",  3'b110, 32'd5, 32'd0, 1, 32'd5);
    run_op("DIVovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run_op("REMovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

    // non-M ALU op (ADD) must not stall or produce a result
    @(posedge clk); #1 mif.inst_E = 32'h002081B3;
    @(negedge clk);
    chk("ADD stall", 32'(mif.md_stall), 32'd0);
    no_valid("ADD valid", 3);

    // flush during iteration 10 abandons the divide
    @(posedge clk); #1;
    mif.inst_E = mk(3'b100); mif.rs1_data = 32'd100; mif.rs2_data = 32'd7;
    repeat (11) @(posedge clk);
    #1 mif.flush = 1'b1;
    @(negedge clk);
    chk("flush stall", 32'(mif.md_stall), 32'd0);
    chk("flush valid", 32'(mif.md_valid), 32'd0);
    @(posedge clk); #1 mif.flush = 1'b0; mif.inst_E = '0;
    no_valid("post-flush valid", 40);
    run_op("DIVU9/2", 3'b101, 32'd9, 32'd2, 33, 32'd4);

    // hold keeps DONE and its result for three cycles
    @(posedge clk); #1 mif.inst_E = '0; mif.hold = 1'b1;
    run_op("MULhold", 3'b000, 32'd6, 32'd7, 2, 32'd42);
    repeat (2) begin
      @(negedge clk);
      chk("hold valid", 32'(mif.md_valid), 32'd1);
      chk("hold result", mif.md_result, 32'd42);
    end
    @(posedge clk); #1 mif.hold = 1'b0;
    @(negedge clk);
    chk("hold release valid", 32'(mif.md_valid), 32'd1);
    @(posedge clk); #1 mif.inst_E = '0;
    @(negedge clk);
    chk("after hold valid", 32'(mif.md_valid), 32'd0);
    chk("after hold result", mif.md_result, 32'd42);

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    mif.inst_E = mk(3'b100); mif.rs1_data = 32'hFFFFFFEC; mif.rs2_data = 32'd3;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1; mif.inst_E = '0;
    #1;
    chk("midrst valid", 32'(mif.md_valid), 32'd0);
    chk("midrst result", mif.md_result, 32'd0);
    chk("midrst stall", 32'(mif.md_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    no_valid("post-rst valid", 40);
    run_op("DIVafter", 3'b100, 32'hFFFFFFEC, 32'd3, 33, 32'hFFFFFFFA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes that register's instruction and operand outputs (after forwarding). Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Raises a stall so the ID/EXE register and earlier stages hold while the operation runs. Presents the result for one advancing cycle, to be muxed into the EXE result path.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- DIV_BITS_PER_CYCLE, 1, quotient bits resolved per DIV iteration (legal 1, 2, 4); iterations N = XLEN/DIV_BITS_PER_CYCLE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- inst_E  in  32  instruction currently held in EXE (ID/EXE register instruction output); 0 = bubble.
- rs1_data  in  32  forwarded rs1 operand.
- rs2_data  in  32  forwarded rs2 operand.
- flush  in  1  kill current EXE instruction (branch redirect, interrupt entry/exit, mispredict).
- hold  in  1  external pipeline freeze (memory stall); pipeline will not advance this cycle.
- md_stall  out  1  request to freeze ID/EXE and earlier stages.
- md_valid  out  1  md_result is valid for the instruction in EXE this cycle.
- md_result  out  32  RV32M result.

Behaviour:
- is_md = (inst_E[6:0]==7'b0110011) && (inst_E[31:25]==7'b0000001); funct3 = inst_E[14:12] selects the op (000 MUL … 111 REMU, per RV32M).
- Reset (async):
  - state=IDLE; md_valid=0; md_result=0; all internal registers 0.
  - md_stall = 0 in reset, since inst_E is 0 out of reset.
- md_stall is combinational: is_md && state!=DONE && !flush.
- IDLE:
  - If is_md && !flush, capture operands and op.
  - MUL ops go to MUL.
  - DIV ops with rs2==0 or signed overflow go to DONE with the special result.
  - Other DIV ops go to DIV with count=0.
  - Otherwise stay in IDLE.
- MUL:
  - Sign/zero-extend each operand to 33 bits: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU and MUL unsigned.
  - Form the 66-bit product into a register.
  - Result is product[31:0] for MUL, product[63:32] otherwise. Go to DONE.
- DIV:
  - Restoring division on |dividend|, |divisor| (abs only for DIV/REM); DIV_BITS_PER_CYCLE bits per cycle.
  - Increment count; go to DONE after N iterations.
  - Final sign fix: quotient negated if operand signs differ (signed ops); remainder takes dividend sign.
- DONE:
  - md_valid=1, md_result=registered result, md_stall=0.
  - If hold, stay in DONE with the result stable.
  - Otherwise go to IDLE.
- Special cases, resolved from IDLE straight to DONE:
  - Divide by zero: DIV/DIVU quotient=32'hFFFFFFFF; REM/REMU = dividend.
  - Overflow, DIV/REM only (rs1=32'h80000000, rs2=32'hFFFFFFFF): quotient=32'h80000000, remainder=0.
- Latency:
  - MUL: 2 stall cycles, result on the 3rd cycle.
  - Normal DIV: N+1 stall cycles (33 at default), result on the next cycle.
  - Special DIV: 1 stall cycle.
- md_valid is 0 outside DONE; md_result holds its last value.
- flush in any state: go to IDLE next edge, no md_valid, operation abandoned; md_stall is low that cycle.
- hold while in MUL or DIV: computation continues; hold only gates the DONE→IDLE exit.
- Back-to-back M ops: the next M instruction enters EXE the cycle after DONE, while the unit is in IDLE, and starts without a gap cycle.
- Non-M instructions and bubbles: md_stall=0, no state change.
- Reset mid-operation: immediate return to reset values; no valid is produced.

Test Plan:
- MUL rs1=7, rs2=-3 (32'hFFFFFFFD) -> md_stall high 2 cycles, then md_valid=1, md_result=32'hFFFFFFEB.
- MULH/MULHSU/MULHU with rs1=32'h80000000, rs2=32'hFFFFFFFF -> 32'h00000000 / 32'h80000000 / 32'h7FFFFFFF.
- DIV rs1=-20, rs2=3 -> 33 stall cycles, quotient 32'hFFFFFFFA; REM same operands -> 32'hFFFFFFFE; DIVU 100/7 -> 14; REMU -> 2.
- DIVU rs1=5, rs2=0 -> 1 stall cycle, md_result=32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000, REM -> 0.
- Start DIV, assert flush at iteration 10 -> next cycle state IDLE, md_stall=0, no md_valid pulse; next DIVU 9/2 -> 4.
- MUL completes with hold=1 for 3 cycles in DONE -> md_valid and md_result stable all 3 cycles, IDLE after hold drops; then async rst mid-DIV -> md_valid=0, md_result=0 immediately.
